inst_sequencer: RTL
===================

# inst_sequencer

- Instruction-issue front end for the `cpu` controller FSM.
- Holds a small loadable program memory of 16-bit instructions and drives `d_inst`/`run` into the controller.
- Waits for the controller's `done` before advancing the program counter; flags end-of-program.
- Sits between the testbench/host load path and the controller, acting as the initiator of the run/done handshake.

## Interface

Parameters:
- `DEPTH`, default 16: program memory entries; power of two.
- `ADDR_W`, default 4: `$clog2(DEPTH)`.
- `TIMEOUT`, default 15: watchdog limit in cycles; used only with `SEQ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  — single clock, all state on rising edge.
- `reset`  in  1  — synchronous, active-low (asserted when 0, sampled on `clk` rising edge).
- `load_en`  in  1  — write `load_data` to `mem[load_addr]`.
- `load_addr`  in  ADDR_W  — program write address.
- `load_data`  in  16  — instruction word.
- `prog_len`  in  ADDR_W+1  — instructions to execute, sampled at start.
- `start`  in  1  — begin execution from address 0.
- `done`  in  1  — controller completion, from `cpu.done`.
- `d_inst`  out  16  — registered instruction to controller.
- `run`  out  1  — one-cycle issue strobe to controller.
- `pc`  out  ADDR_W  — address of current instruction.
- `busy`  out  1  — high in any state except IDLE.
- `prog_done`  out  1  — one-cycle pulse after last instruction completes.
- `err`  out  1  — sticky watchdog error; constant 0 without `SEQ_TIMEOUT_EN`.

## Operation

FSM states:
- IDLE: accepts loads and start.
- ISSUE: `run` = 1 for exactly one cycle.
- WAIT: waits for `done`.

Transitions:
- IDLE → ISSUE on `start` = 1 with effective length ≥ 1.
  - Latch `len` = min(`prog_len`, DEPTH).
  - `pc` <= 0, `d_inst` <= mem[0].
- ISSUE → WAIT unconditionally.
- WAIT, `done` = 1 and `pc` == `len`-1 → IDLE, `prog_done` pulses.
- WAIT, `done` = 1 otherwise → ISSUE; `pc` <= `pc`+1, `d_inst` <= mem[`pc`+1].

Memory and loading:
- `load_en` is honoured only in IDLE and only when `start` is not accepted that cycle; `start` wins.
- Loads while busy are dropped.
- Memory is not reset; contents survive reset.

Handshake and boundary rules:
- `d_inst` stays stable from ISSUE until the edge that samples `done` = 1. The controller reads `d_inst[15:13]` during its done cycle.
- `done` is ignored in IDLE and ISSUE.
- `start` is ignored while `busy`.
- `start` with `prog_len` = 0 is ignored; FSM stays IDLE and `prog_done` is not pulsed.
- `prog_len` > DEPTH is clamped to DEPTH.
- `pc` never wraps: the last legal index is `len`-1.
- Reset low mid-program → IDLE on the next edge; outputs return to reset values.

Reset values: `d_inst` = 0, `run` = 0, `pc` = 0, `busy` = 0, `prog_done` = 0, `err` = 0, state IDLE.

## Timing

- `start` sampled at edge E0 → cycle 1: ISSUE, `run` = 1, `d_inst` = mem[0].
- Cycle 2: WAIT.
- The controller leaves S0 on the edge ending cycle 1 and reaches S2 (`done` = 1) in cycle 3.
- `done` sampled at the end of cycle 3 → cycle 4: ISSUE with mem[1].
- Steady state: 3 cycles per instruction against `cpu`; N instructions take 3N cycles from start to the `prog_done` cycle.
- `prog_done` is high in the cycle after the final `done` (cycle 3N+1) while state is IDLE.
- All outputs are registered; no combinational path from `done` to any output.

## Configuration

- `SEQ_TIMEOUT_EN` defined:
  - 5-bit watchdog counts cycles in WAIT; it is cleared on entering WAIT.
  - When the count reaches `TIMEOUT` without `done`: → IDLE, `err` <= 1 (sticky until reset or next accepted `start`), no `prog_done`.
- `SEQ_TIMEOUT_EN` undefined:
  - No watchdog; WAIT persists indefinitely.
  - `err` tied to 0.

## Test plan

- Load mem[0..2] = 16'h2004, 16'h4408, 16'h600C; `prog_len` = 3; start with `cpu` attached → `run` pulses in cycles 1, 4, 7; `d_inst` matches each word in order; `prog_done` pulses in cycle 10; `pc` sequence 0, 1, 2.
- `prog_len` = 0 with start → no `run`, `busy` stays 0, no `prog_done`.
- `prog_len` = 20 with DEPTH = 16 → exactly 16 `run` pulses, then `prog_done`.
- `load_en` to addr 1 during WAIT of instruction 0 → memory is unchanged; a second program run issues the original mem[1].
- Reset low in WAIT of instruction 2 → next cycle all outputs are 0, state IDLE; a subsequent start re-runs from mem[0] with memory intact.
- `SEQ_TIMEOUT_EN`, `done` held 0 → IDLE with `err` = 1 after 15 WAIT cycles and no `prog_done`; the next start clears `err`.

Source files
------------

// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - instruction-issue front end for the cpu controller FSM
//
// Holds a loadable program memory of 16-bit instructions and feeds them one
// at a time to the controller, issuing a one-cycle run strobe and waiting for
// the controller's done before moving to the next word.
//
// Optional feature macro: SEQ_TIMEOUT_EN (WAIT-state watchdog driving err).
//
// Ports:
//   clk        in   1         rising-edge clock
//   reset      in   1         synchronous, active-low
//   load_en    in   1         write load_data into mem[load_addr] (IDLE only)
//   load_addr  in   ADDR_W    program write address
//   load_data  in   16        instruction word
//   prog_len   in   ADDR_W+1  number of instructions, sampled at start
//   start      in   1         begin execution from address 0
//   done       in   1         controller completion
//   d_inst     out  16        registered instruction to the controller
//   run        out  1         one-cycle issue strobe
//   pc         out  ADDR_W    address of the current instruction
//   busy       out  1         high whenever not IDLE
//   prog_done  out  1         one-cycle pulse after the last instruction
//   err        out  1         sticky watchdog error (0 without the watchdog)

module inst_sequencer #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              done,
  output logic [15:0]       d_inst,
  output logic              run,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              prog_done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR0   = '0;
  localparam logic [ADDR_W-1:0] ADDR1   = ADDR_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   eff_len;
  logic [ADDR_W-1:0] pc_inc;
  logic              start_acc;
  logic              last_inst;
  logic              done_ok;
  logic              wd_hit;

  // Lengths beyond the memory size are clamped so pc can never wrap.
  assign eff_len   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign start_acc = (state == S_IDLE) && start && (eff_len != '0);
  assign last_inst = ({1'b0, pc} == (len - ONE_L));
  assign pc_inc    = pc + ADDR1;
  // done only has meaning while an instruction is outstanding.
  assign done_ok   = (state == S_WAIT) && done;

`ifdef SEQ_TIMEOUT_EN
  logic [4:0] wd_cnt;

  // wd_cnt holds (WAIT cycles so far - 1), so the hit fires in the
  // TIMEOUT-th consecutive WAIT cycle without done.
  assign wd_hit = (state == S_WAIT) && !done && (wd_cnt == 5'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt <= 5'd0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= (state == S_WAIT) ? wd_cnt + 5'd1 : 5'd0;
      if (start_acc) begin
        err <= 1'b0;
      end else if (wd_hit) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic timeout_unused;

  // Without the watchdog WAIT lasts until done; TIMEOUT has no effect.
  assign timeout_unused = |5'(TIMEOUT);
  assign wd_hit         = 1'b0;
  assign err            = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_acc) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          state_nxt = last_inst ? S_IDLE : S_ISSUE;
        end else if (wd_hit) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      run       <= 1'b0;
      busy      <= 1'b0;
      prog_done <= 1'b0;
      pc        <= '0;
      d_inst    <= 16'h0000;
      len       <= '0;
    end else begin
      state     <= state_nxt;
      run       <= (state_nxt == S_ISSUE);
      busy      <= (state_nxt != S_IDLE);
      prog_done <= done_ok && last_inst;
      if (start_acc) begin
        len    <= eff_len;
        pc     <= ADDR0;
        d_inst <= mem[ADDR0];
      end else if (done_ok && !last_inst) begin
        // d_inst only changes on the edge that samples done, keeping it
        // stable for the controller throughout ISSUE and WAIT.
        pc     <= pc_inc;
        d_inst <= mem[pc_inc];
      end
    end
  end

  // Program memory is not reset. A start in the same cycle takes priority
  // over a load, and loads outside IDLE are dropped.
  always_ff @(posedge clk) begin
    if (reset && load_en && (state == S_IDLE) && !start_acc) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule
